// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC packet scheduler: FSM states, header layout
// and small combinational helpers.
package adc_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_e;

  localparam int CH_W = 4;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

  // Header bit positions within the 96-bit header beat
  localparam int HDR_MAGIC_LSB = 80;
  localparam int HDR_RSVD_LSB  = 76;
  localparam int HDR_CH_LSB    = 72;
  localparam int HDR_SEQ_LSB   = 56;
  localparam int HDR_LEN_LSB   = 48;

  function automatic logic [95:0] hdr_pack(input logic [CH_W-1:0] ch,
                                           input logic [15:0]     seq,
                                           input logic [7:0]      len);
    logic [95:0] h;
    h = 96'd0;
    h[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
    h[HDR_RSVD_LSB +: 4]   = 4'h0;
    h[HDR_CH_LSB +: CH_W]  = ch;
    h[HDR_SEQ_LSB +: 16]   = seq;
    h[HDR_LEN_LSB +: 8]    = len;
    return h;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [CH_W-1:0] lowest_set(input logic [15:0] v);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = v[i] ? CH_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_pkt_sched_rr_arb.sv
// Round-robin lane picker: first requesting lane strictly above last_ch,
// wrapping to the lowest requesting lane.
module rr_arb
  import adc_pkt_pkg::*;
#(
  parameter int NUM_CH = 9
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_ch,
  output logic              gnt_vld,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [NUM_CH-1:0] upper_s;

  // Requests that sit after the previous winner in round-robin order
  always_comb begin
    upper_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upper_s[i] = req[i] & (CH_W'(i) > last_ch);
    end
  end

  assign gnt_vld = |req;
  assign gnt_idx = (|upper_s) ? lowest_set(16'(upper_s)) : lowest_set(16'(req));

endmodule

// File: rtl/adc_pkt_sched.sv
// Round-robin packet scheduler: grants one ADC lane at a time and streams a
// header beat plus a fixed-length burst of that lane's words.
module adc_pkt_sched
  import adc_pkt_pkg::*;
#(
  parameter int NUM_CH  = 9,
  parameter int DW      = 96,
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  input  logic [NUM_CH-1:0]    cfg_ch_mask,
  input  logic [7:0]           cfg_pkt_len,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH*DW-1:0] data_in,
  output logic [NUM_CH-1:0]    ch_pop,
  output logic [3:0]           sel_ch,
  output logic                 pkt_vld,
  input  logic                 pkt_rdy,
  output logic                 pkt_sop,
  output logic                 pkt_eop,
  output logic [DW-1:0]        pkt_data,
  output logic                 busy,
  output logic [15:0]          pkt_seq
);

  localparam logic [7:0] GAP_LAST = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

  state_e          state_r, state_nxt_s;
  logic [CH_W-1:0] cur_ch_r, cur_ch_nxt_s;
  logic [CH_W-1:0] last_ch_r, last_ch_nxt_s;
  logic [7:0]      beat_cnt_r, beat_cnt_nxt_s;
  logic [7:0]      len_eff_r, len_eff_nxt_s;
  logic [7:0]      gap_cnt_r, gap_cnt_nxt_s;
  logic [15:0]     seq_r, seq_nxt_s;

  logic [NUM_CH-1:0] elig_s;
  logic              gnt_vld_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [NUM_CH-1:0] lane_sel_s;
  logic [DW-1:0]     lane_data_s;
  logic              lane_req_s;
  logic              last_beat_s;

  assign elig_s = ch_req & cfg_ch_mask;

  rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_rr_arb (
    .req     (elig_s),
    .last_ch (last_ch_r),
    .gnt_vld (gnt_vld_s),
    .gnt_idx (gnt_idx_s)
  );

  // Select the granted lane's request level and data word
  always_comb begin
    lane_sel_s  = '0;
    lane_data_s = '0;
    lane_req_s  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_sel_s[i] = (cur_ch_r == CH_W'(i));
      lane_data_s   = lane_data_s | (data_in[i*DW +: DW] & {DW{lane_sel_s[i]}});
      lane_req_s    = lane_req_s | (ch_req[i] & lane_sel_s[i]);
    end
  end

  assign last_beat_s = (beat_cnt_r == (len_eff_r - 8'd1));

  // Next-state and beat outputs; valid never depends on pkt_rdy
  always_comb begin
    state_nxt_s    = state_r;
    cur_ch_nxt_s   = cur_ch_r;
    last_ch_nxt_s  = last_ch_r;
    beat_cnt_nxt_s = beat_cnt_r;
    len_eff_nxt_s  = len_eff_r;
    gap_cnt_nxt_s  = gap_cnt_r;
    seq_nxt_s      = seq_r;
    pkt_vld        = 1'b0;
    pkt_sop        = 1'b0;
    pkt_eop        = 1'b0;
    pkt_data       = '0;
    ch_pop         = '0;
    case (state_r)
      IDLE: begin
        if (cfg_en) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARB: begin
        if (!cfg_en) begin
          state_nxt_s = IDLE;
        end else if (gnt_vld_s) begin
          state_nxt_s   = HDR;
          cur_ch_nxt_s  = gnt_idx_s;
          len_eff_nxt_s = (cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len;
        end else begin
          state_nxt_s = ARB;
        end
      end
      HDR: begin
        pkt_vld  = 1'b1;
        pkt_sop  = 1'b1;
        pkt_data = DW'(hdr_pack(cur_ch_r, seq_r, len_eff_r));
        if (pkt_rdy) begin
          state_nxt_s    = DATA;
          beat_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = HDR;
        end
      end
      DATA: begin
        // A dropped lane request simply pauses the burst
        pkt_vld  = lane_req_s;
        pkt_data = lane_data_s;
        pkt_eop  = last_beat_s;
        if (lane_req_s && pkt_rdy) begin
          ch_pop = lane_sel_s;
          if (last_beat_s) begin
            last_ch_nxt_s = cur_ch_r;
            seq_nxt_s     = seq_r + 16'd1;
            gap_cnt_nxt_s = 8'd0;
            state_nxt_s   = (GAP_CYC == 0) ? ARB : GAP;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 8'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ARB;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Scheduler state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cur_ch_r   <= '0;
      last_ch_r  <= CH_W'(NUM_CH - 1);
      beat_cnt_r <= 8'd0;
      len_eff_r  <= 8'd1;
      gap_cnt_r  <= 8'd0;
      seq_r      <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      cur_ch_r   <= cur_ch_nxt_s;
      last_ch_r  <= last_ch_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      len_eff_r  <= len_eff_nxt_s;
      gap_cnt_r  <= gap_cnt_nxt_s;
      seq_r      <= seq_nxt_s;
    end
  end

  assign sel_ch  = cur_ch_r;
  assign busy    = (state_r != IDLE);
  assign pkt_seq = seq_r;

endmodule

// File: doc/adc_pkt_sched.md
# adc_pkt_sched

Round-robin packet scheduler between the nine ADC capture lanes and the packet generator in the packet-control subsystem. It picks one requesting, enabled lane at a time and emits a header beat followed by a fixed-length burst of that lane's 96-bit words over a valid/ready interface. It also drives the lane-select index consumed by the ADC data selector. Packets are never interleaved; arbitration happens only between packets.

## Interface
Parameters:
- NUM_CH, 9, number of ADC lanes
- DW, 96, lane/beat width
- GAP_CYC, 2, idle cycles inserted after each packet (0 allowed)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cfg_en  in  1  scheduler enable
- cfg_ch_mask  in  NUM_CH  per-lane enable
- cfg_pkt_len  in  8  data beats per packet (0 treated as 1)
- ch_req  in  NUM_CH  lane has a word available (level)
- data_in  in  NUM_CH*DW  packed lane data, lane i at [i*DW +: DW]
- ch_pop  out  NUM_CH  one-hot, lane word consumed this cycle
- sel_ch  out  4  current lane index
- pkt_vld  out  1  beat valid
- pkt_rdy  in  1  downstream ready
- pkt_sop / pkt_eop  out  1  first / last beat of packet
- pkt_data  out  DW  beat payload
- busy  out  1  state != IDLE
- pkt_seq  out  16  sequence number of the current/last packet

## Operation
- FSM states: IDLE, ARB, HDR, DATA, GAP.
- IDLE: go to ARB when cfg_en=1.
- ARB: eligible = ch_req & cfg_ch_mask.
  - If cfg_en=0, go to IDLE.
  - Otherwise, if eligible != 0, pick the first eligible lane searching upward from last_ch+1 with wrap (last_ch resets to NUM_CH-1, so lane 0 wins first), register it as cur_ch, and go to HDR.
  - Otherwise stay in ARB.
- HDR: pkt_vld=1, pkt_sop=1.
  - pkt_data = {16'hA5C3, 4'h0, cur_ch, pkt_seq, len_eff, 48'h0}.
  - On pkt_vld&pkt_rdy, go to DATA; beat_cnt=0.
- DATA: pkt_vld = ch_req[cur_ch]; pkt_data = lane cur_ch of data_in.
  - ch_pop[cur_ch] = pkt_vld & pkt_rdy.
  - pkt_eop=1 when beat_cnt==len_eff-1.
  - On an accepted eop beat, last_ch<=cur_ch, pkt_seq<=pkt_seq+1 (16-bit wrap), and go to GAP; if GAP_CYC=0, go directly to ARB.
- GAP: count GAP_CYC cycles, then go to ARB.
- len_eff = max(cfg_pkt_len,1), latched in ARB on grant. cfg changes mid-packet do not affect the current packet.
- sel_ch = cur_ch in all states.
- pkt_seq reflects the header of the current packet and increments after its eop.

Boundary conditions:
- ch_req[cur_ch] drops in DATA: pkt_vld deasserts, no pop, beat_cnt holds; no timeout, packet resumes.
- cfg_ch_mask[cur_ch] cleared mid-packet: ignored until the packet completes.
- cfg_en=0 mid-packet: the packet completes, then GAP, then ARB sees cfg_en=0 and goes to IDLE.
- pkt_rdy=0: all outputs hold stable while pkt_vld=1.
- Reset mid-packet: immediate return to IDLE; the partial packet is abandoned with no eop.

## Timing
- Reset values: pkt_vld=0, pkt_sop=0, pkt_eop=0, pkt_data=0, ch_pop=0, sel_ch=0, busy=0, pkt_seq=0; state=IDLE, cur_ch=0, last_ch=NUM_CH-1, beat_cnt=0.
- cfg_en rising edge: ARB on the next edge; with eligible lanes present, HDR is valid 2 cycles after cfg_en is sampled.
- Packet occupancy with pkt_rdy=1 and ch_req=1: 1 ARB + 1 HDR + len_eff DATA + GAP_CYC cycles.
- pkt_vld, pkt_data, and ch_pop are combinational from state and data_in/ch_req. No combinational path from pkt_rdy to pkt_vld.
- Next-state logic is registered; beat_cnt is 8 bits.

## Structure
- Shared package adc_pkt_pkg:
  - state enum (IDLE, ARB, HDR, DATA, GAP)
  - HDR_MAGIC=16'hA5C3
  - header field offsets
- Sub-module rr_arb (NUM_CH): inputs req, last_ch; outputs gnt_vld, gnt_idx.

## Test plan
- Reset, cfg_en=1, mask=9'h1FF, ch_req=9'h1FF, len=4, rdy=1 -> lanes granted in order 0,1,2,…,8,0; each packet is HDR plus 4 beats; pkt_seq 0..9; HDR beat 0 = {A5C3,0,0,0000,04,0}.
- ch_req=9'h104, mask=9'h1FF -> grants alternate 2,8,2,8.
- Toggle pkt_rdy randomly, and drop ch_req[cur] for 3 cycles mid-DATA -> data stable under stall; exactly len_eff pops per packet; no pop while vld=0.
- cfg_pkt_len=0 -> HDR plus 1 beat with sop then eop; len field=1. cfg_en=0 during DATA -> packet completes, then busy=0 after GAP+1.
- rst_n=0 in DATA beat 2 -> next cycle all outputs at reset values; next packet after restart grants lane 0 with seq 0.
- mask=9'h010, ch_req=9'h1EF -> no grant, stays in ARB, pkt_vld=0; setting ch_req[4] -> grant lane 4.
